// File: rtl/rare_mon_pkg.sv
// Shared types and sizing helpers for the rare-net activity monitor.
package rare_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    REPORT
  } state_t;

  function automatic int win_w(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rare_net_activity_monitor_if.sv
// Control, net tap and readout bundle of the rare-net activity monitor.
interface rare_net_activity_monitor_if #(
  parameter int N_NETS = 8,
  parameter int CNT_W  = 8
) ();
  import rare_mon_pkg::*;

  localparam int SEL_W = sel_w(N_NETS);

  logic              start;
  logic              abort;
  logic              sample_en;
  logic [N_NETS-1:0] net_in;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_cnt;
  logic              busy;
  logic              done;
  logic [N_NETS-1:0] rare_mask;

  modport master (
    output start, abort, sample_en, net_in, rd_sel,
    input  rd_cnt, busy, done, rare_mask
  );

  modport slave (
    input  start, abort, sample_en, net_in, rd_sel,
    output rd_cnt, busy, done, rare_mask
  );

endinterface

// File: rtl/toggle_sat_counter.sv
// Per-net toggle counter: remembers the last sample and counts changes,
// saturating at all-ones.
module toggle_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [CNT_W-1:0] q
);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tog;
  logic             w_sat;

  assign w_tog = d ^ r_prev;
  assign w_sat = &r_cnt;

  // clr also reloads the reference sample so the first count starts clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_prev <= d;
      r_cnt  <= '0;
    end else if (en) begin
      r_prev <= d;
      if (w_tog && !w_sat)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign q = r_cnt;

endmodule

// File: rtl/rare_net_activity_monitor.sv
// Counts per-net toggles over a window of enabled samples and flags
// nets whose activity stays below a threshold.
module rare_net_activity_monitor
  import rare_mon_pkg::*;
#(
  parameter int N_NETS      = 8,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 256,
  parameter int RARE_THRESH = 2
) (
  input logic                        I1470_clk,
  input logic                        I1477_rst,
  rare_net_activity_monitor_if.slave bus
);

  localparam int               WIN_W   = win_w(WINDOW);
  localparam logic [WIN_W-1:0] WIN_END = WIN_W'(WINDOW);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RARE_THRESH);

  state_t             r_state;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   w_win_nx;
  logic               r_busy;
  logic               r_done;
  logic [N_NETS-1:0]  r_mask;
  logic [N_NETS-1:0]  w_rare;
  logic               w_clr;
  logic               w_en;
  logic [CNT_W-1:0]   w_cnt [N_NETS];
  logic [CNT_W-1:0]   w_rd;

  // clear on the start edge, then again in ARM to capture the reference
  assign w_clr = !bus.abort &&
                 (((r_state == IDLE) && bus.start) || (r_state == ARM));
  assign w_en  = !bus.abort && (r_state == COUNT) && bus.sample_en;

  for (genvar g = 0; g < N_NETS; g++) begin : g_net
    toggle_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (I1470_clk),
      .rst (I1477_rst),
      .clr (w_clr),
      .en  (w_en),
      .d   (bus.net_in[g]),
      .q   (w_cnt[g])
    );
    assign w_rare[g] = w_cnt[g] < THRESH;
  end

  assign w_win_nx = r_win + WIN_W'(1);

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mask  <= '0;
    end else if (bus.abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_state <= ARM;
          r_busy  <= 1'b1;
          r_win   <= '0;
        end
        ARM: r_state <= COUNT;
        COUNT: if (bus.sample_en) begin
          r_win <= w_win_nx;
          if (w_win_nx == WIN_END) begin
            r_state <= REPORT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        REPORT: begin
          r_state <= IDLE;
          r_mask  <= w_rare;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // counters are frozen in REPORT, so the live compare is the final result
  assign bus.rare_mask = (r_state == REPORT) ? w_rare : r_mask;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < N_NETS; i++)
      if (int'(bus.rd_sel) == i)
        w_rd = w_cnt[i];
  end

  assign bus.rd_cnt = w_rd;

endmodule

// File: tb/tb_rare_net_activity_monitor.sv
// Bench for the rare-net activity monitor: three configurations driven
// with directed and random net activity against a sample-list model.
module tb_rare_net_activity_monitor;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #10 clk = ~clk;

  rare_net_activity_monitor_if #(.N_NETS(8), .CNT_W(8)) ifa ();
  rare_net_activity_monitor_if #(.N_NETS(6), .CNT_W(3)) ifb ();
  rare_net_activity_monitor_if #(.N_NETS(5), .CNT_W(4)) ifc ();

  rare_net_activity_monitor #(
    .N_NETS(8), .CNT_W(8), .WINDOW(16), .RARE_THRESH(2)
  ) dut_a (.I1470_clk(clk), .I1477_rst(rst), .bus(ifa));

  rare_net_activity_monitor #(
    .N_NETS(6), .CNT_W(3), .WINDOW(20), .RARE_THRESH(2)
  ) dut_b (.I1470_clk(clk), .I1477_rst(rst), .bus(ifb));

  rare_net_activity_monitor #(
    .N_NETS(5), .CNT_W(4), .WINDOW(1), .RARE_THRESH(2)
  ) dut_c (.I1470_clk(clk), .I1477_rst(rst), .bus(ifc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // toggles of one net across the list of samples the monitor should see
  function automatic logic [31:0] model_cnt(input logic [7:0] s[$],
                                            input int b, input int maxv);
    int n;
    n = 0;
    for (int j = 1; j < s.size(); j++)
      if (s[j][b] != s[j-1][b]) n++;
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  function automatic logic [7:0] model_mask(input logic [7:0] s[$],
                                            input int n, input int maxv,
                                            input int thr);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < n; b++)
      m[b] = model_cnt(s, b, maxv) < 32'(thr);
    return m;
  endfunction

  // mode 0: directed, 1: alternate enable, 2: random enable
  task automatic run_a(input int mode, input bit mid,
                       output logic [7:0] mexp);
    logic [7:0] s[$];
    logic [7:0] net;
    int k;
    bit en, early, idle;
    early = 0;
    idle  = 0;
    k     = 0;
    net = 8'($urandom);
    ifa.net_in    = net;
    ifa.sample_en = 1'b0;
    ifa.start     = 1'b1;
    tick;
    ifa.start = 1'b0;
    s.push_back(net);
    tick;
    while (s.size() < 17 && k < 100) begin
      if (ifa.done) early = 1;
      if (!ifa.busy) idle = 1;
      case (mode)
        0: begin
          net[0] = ~net[0];
          if (k == 7) net[1] = ~net[1];
          en = 1;
        end
        1: begin
          net = net ^ 8'($urandom & $urandom & $urandom);
          en  = (k % 2) == 1;
        end
        default: begin
          net = net ^ 8'($urandom & $urandom & $urandom);
          en  = $urandom_range(3) != 0;
        end
      endcase
      ifa.net_in    = net;
      ifa.sample_en = en;
      ifa.start     = mid && (k == 3);
      tick;
      k++;
      if (en) s.push_back(net);
    end
    ifa.sample_en = 1'b0;
    ifa.start     = 1'b0;
    mexp = model_mask(s, 8, 255, 2);
    chk("a_done", 32'(ifa.done), 1);
    chk("a_early_done", 32'(early), 0);
    chk("a_busy_gap", 32'(idle), 0);
    chk("a_busy_off", 32'(ifa.busy), 0);
    chk("a_mask", 32'(ifa.rare_mask), 32'(mexp));
    for (int b = 0; b < 8; b++) begin
      ifa.rd_sel = 3'(b);
      #1;
      chk($sformatf("a_cnt%0d", b), 32'(ifa.rd_cnt), model_cnt(s, b, 255));
    end
    if (mode == 0) begin
      ifa.rd_sel = 3'd0;
      #1;
      chk("a_basic_cnt0", 32'(ifa.rd_cnt), 16);
      ifa.rd_sel = 3'd1;
      #1;
      chk("a_basic_cnt1", 32'(ifa.rd_cnt), 1);
      chk("a_basic_mask", 32'(ifa.rare_mask), 'hFE);
    end
    tick;
    chk("a_done_pulse", 32'(ifa.done), 0);
    chk("a_mask_hold", 32'(ifa.rare_mask), 32'(mexp));
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] net, m, mprev;
    logic [31:0] part0;
    int k;
    bit flag;

    ifa.start = 0; ifa.abort = 0; ifa.sample_en = 0;
    ifa.net_in = '0; ifa.rd_sel = '0;
    ifb.start = 0; ifb.abort = 0; ifb.sample_en = 0;
    ifb.net_in = '0; ifb.rd_sel = '0;
    ifc.start = 0; ifc.abort = 0; ifc.sample_en = 0;
    ifc.net_in = '0; ifc.rd_sel = '0;

    rst = 1'b1;
    tick;
    tick;
    chk("rst0_busy", 32'(ifa.busy), 0);
    chk("rst0_done", 32'(ifa.done), 0);
    chk("rst0_mask", 32'(ifa.rare_mask), 0);
    chk("rst0_rdcnt", 32'(ifa.rd_cnt), 0);
    rst = 1'b0;
    tick;

    run_a(0, 0, m);
    run_a(1, 0, m);
    run_a(2, 1, m);
    run_a(2, 0, m);
    mprev = m;

    // abort after five samples
    s.delete();
    net = 8'($urandom);
    ifa.net_in = net;
    ifa.start  = 1'b1;
    tick;
    ifa.start = 1'b0;
    s.push_back(net);
    tick;
    for (int j = 0; j < 5; j++) begin
      net = net ^ 8'h01 ^ 8'($urandom & $urandom & $urandom & 32'hFE);
      ifa.net_in    = net;
      ifa.sample_en = 1'b1;
      tick;
      s.push_back(net);
    end
    ifa.sample_en = 1'b0;
    ifa.abort     = 1'b1;
    tick;
    ifa.abort = 1'b0;
    chk("ab_busy", 32'(ifa.busy), 0);
    chk("ab_done", 32'(ifa.done), 0);
    for (int b = 0; b < 8; b++) begin
      ifa.rd_sel = 3'(b);
      #1;
      chk($sformatf("ab_cnt%0d", b), 32'(ifa.rd_cnt), model_cnt(s, b, 255));
    end
    part0 = model_cnt(s, 0, 255);
    flag = 0;
    repeat (20) begin
      ifa.sample_en = 1'b1;
      ifa.net_in    = 8'($urandom);
      tick;
      if (ifa.done || ifa.busy) flag = 1;
    end
    ifa.sample_en = 1'b0;
    chk("ab_no_done", 32'(flag), 0);
    chk("ab_mask_kept", 32'(ifa.rare_mask), 32'(mprev));
    ifa.rd_sel = 3'd0;
    #1;
    chk("ab_cnt_hold", 32'(ifa.rd_cnt), part0);

    // start and abort together: abort wins, nothing clears
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    tick;
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    chk("sa_busy", 32'(ifa.busy), 0);
    tick;
    chk("sa_idle", 32'(ifa.busy), 0);
    chk("sa_no_clr", 32'(ifa.rd_cnt), part0);

    // saturation with a 3-bit counter over 20 samples
    s.delete();
    net = 8'($urandom) & 8'h3F;
    ifb.net_in = net[5:0];
    ifb.start  = 1'b1;
    tick;
    ifb.start = 1'b0;
    s.push_back(net);
    tick;
    flag = 0;
    k = 0;
    while (s.size() < 21 && k < 100) begin
      if (ifb.done) flag = 1;
      net = net ^ 8'h01 ^ (8'($urandom & $urandom & $urandom) & 8'h3E);
      ifb.net_in    = net[5:0];
      ifb.sample_en = 1'b1;
      tick;
      k++;
      s.push_back(net);
    end
    ifb.sample_en = 1'b0;
    m = model_mask(s, 6, 7, 2);
    chk("b_done", 32'(ifb.done), 1);
    chk("b_early_done", 32'(flag), 0);
    chk("b_mask", 32'(ifb.rare_mask), 32'(m));
    chk("b_mask0", 32'(ifb.rare_mask[0]), 0);
    for (int b = 0; b < 6; b++) begin
      ifb.rd_sel = 3'(b);
      #1;
      chk($sformatf("b_cnt%0d", b), 32'(ifb.rd_cnt), model_cnt(s, b, 7));
    end
    ifb.rd_sel = 3'd0;
    #1;
    chk("b_sat7", 32'(ifb.rd_cnt), 7);
    for (int b = 6; b < 8; b++) begin
      ifb.rd_sel = 3'(b);
      #1;
      chk($sformatf("b_oor%0d", b), 32'(ifb.rd_cnt), 0);
    end

    // single-sample window
    s.delete();
    net = 8'($urandom) & 8'h1F;
    ifc.net_in = net[4:0];
    ifc.start  = 1'b1;
    tick;
    ifc.start = 1'b0;
    s.push_back(net);
    tick;
    chk("c_not_yet", 32'(ifc.done), 0);
    net = 8'($urandom) & 8'h1F;
    ifc.net_in    = net[4:0];
    ifc.sample_en = 1'b1;
    tick;
    ifc.sample_en = 1'b0;
    s.push_back(net);
    m = model_mask(s, 5, 15, 2);
    chk("c_done", 32'(ifc.done), 1);
    chk("c_mask", 32'(ifc.rare_mask), 32'(m));
    for (int b = 0; b < 8; b++) begin
      ifc.rd_sel = 3'(b);
      #1;
      chk($sformatf("c_cnt%0d", b), 32'(ifc.rd_cnt),
          (b < 5) ? model_cnt(s, b, 15) : 32'd0);
    end
    tick;
    chk("c_done_pulse", 32'(ifc.done), 0);

    // reset in the middle of a window
    run_a(0, 0, m);
    ifa.start = 1'b1;
    tick;
    ifa.start = 1'b0;
    tick;
    repeat (5) begin
      ifa.net_in    = 8'($urandom);
      ifa.sample_en = 1'b1;
      tick;
    end
    rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(ifa.busy), 0);
    repeat (3) tick;
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_done", 32'(ifa.done), 0);
    chk("rst_mask", 32'(ifa.rare_mask), 0);
    for (int b = 0; b < 8; b++) begin
      ifa.rd_sel = 3'(b);
      #1;
      chk($sformatf("rst_cnt%0d", b), 32'(ifa.rd_cnt), 0);
    end
    rst = 1'b0;
    flag = 0;
    repeat (20) begin
      ifa.net_in    = 8'($urandom);
      ifa.sample_en = 1'b1;
      tick;
      if (ifa.done || ifa.busy) flag = 1;
    end
    ifa.sample_en = 1'b0;
    chk("rst_no_done", 32'(flag), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
